controller: RTL and testbench

Single-cycle execution core of the FLU processor. Each rising clock edge it decodes the 32-bit instruction on `control`, reads two operands from an internal 32×32 register file, and computes a logic/arithmetic/shift result. It writes the result back to the register file and presents it on the registered `out` port. There is no fetch, memory or branch logic; the instruction is driven directly by the enclosing design.

---
 rtl/controller.sv | 78 +++++++
 tb/tb_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/controller.sv
// Single-cycle FLU execution core: decodes the instruction word, reads two
// operands from a 32x32 register file, executes, and writes back every edge.
module controller (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] control,
  output logic [31:0] out
);

  localparam int         NUM_REGS   = 32;
  localparam int         DATA_W     = 32;
  localparam logic [5:0] FUNCT_EXEC = 6'b001011;

  typedef enum logic [5:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_AND  = 6'd2,
    OP_OR   = 6'd3,
    OP_XOR  = 6'd4,
    OP_NOR  = 6'd5,
    OP_SLL  = 6'd6,
    OP_SRL  = 6'd7,
    OP_SRA  = 6'd8,
    OP_SLT  = 6'd9,
    OP_SLTU = 6'd10
  } op_e;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } insn_t;

  insn_t             insn;
  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [DATA_W-1:0] a, b, res;
  logic              valid;

  assign insn = insn_t'(control);

  // R0 is forced to zero on read; its storage is never written after reset.
  assign a = (insn.rs == 5'd0) ? '0 : rf[insn.rs];
  assign b = (insn.rt == 5'd0) ? '0 : rf[insn.rt];

  always_comb begin
    res   = '0;
    valid = (insn.funct == FUNCT_EXEC);
    case (insn.op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_SLL:  res = b << insn.shamt;
      OP_SRL:  res = b >> insn.shamt;
      OP_SRA:  res = $unsigned($signed(b) >>> insn.shamt);
      OP_SLT:  res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res = {{(DATA_W-1){1'b0}}, (a < b)};
      default: valid = 1'b0;
    endcase
  end

  // Operands come from pre-edge contents, so rd==rs/rt sees the old value.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= DATA_W'(i);
    end else if (valid) begin
      out <= res;
      if (insn.rd != 5'd0) rf[insn.rd] <= res;
    end
  end

endmodule

// File: tb/tb_controller.sv
// Randomized bench for controller against an instruction-level reference model,
// plus directed scenarios with hand-computed results.
module tb_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] control;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

  logic [31:0] mr [32];
  logic [31:0] mout;

  controller dut (
    .clock   (clock),
    .reset_n (reset_n),
    .control (control),
    .out     (out)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [4:0] sh,
                                     input logic [5:0] fn = 6'b001011);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  function automatic bit m_valid(input logic [31:0] w);
    return (w[5:0] == 6'b001011) && (w[31:26] <= 6'd10);
  endfunction

  // Result of an instruction given the current model register contents.
  function automatic logic [31:0] m_exec(input logic [31:0] w);
    logic [31:0] x, y;
    logic [63:0] ext;
    int sh;
    x  = (w[25:21] == 0) ? 32'd0 : mr[w[25:21]];
    y  = (w[20:16] == 0) ? 32'd0 : mr[w[20:16]];
    sh = int'(w[10:6]);
    ext = {{32{y[31]}}, y};
    case (int'(w[31:26]))
      0:  return x + y;
      1:  return x + (~y + 32'd1);
      2:  return x & y;
      3:  return x | y;
      4:  return x ^ y;
      5:  return ~(x | y);
      6:  return y << sh;
      7:  return y >> sh;
      8:  return ext[31:0] >> 0 == 0 ? 32'd0 : 32'(ext >> sh);
      9:  return {31'd0, (x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)};
      10: return {31'd0, x < y};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      mout <= 32'd0;
      for (int i = 0; i < 32; i++) mr[i] <= 32'(i);
    end else if (m_valid(control)) begin
      mout <= m_exec(control);
      if (control[15:11] != 5'd0) mr[control[15:11]] <= m_exec(control);
    end
  end

  always @(negedge clock) begin
    if (run_chk) begin
      checks++;
      if (out !== mout) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t ctl=%h out=%h expected=%h", $time, control, out, mout);
      end
    end
  end

  task automatic apply(input logic [31:0] ctl, input logic rn, input int cycles);
    control = ctl;
    reset_n = rn;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic lit(input string name, input logic [31:0] exp);
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL %s dut out=%h expected=%h", name, out, exp);
    end
    checks++;
    if (mout !== exp) begin
      errors++;
      $display("FAIL %s_model model=%h expected=%h", name, mout, exp);
    end
  endtask

  initial begin
    logic [31:0] w;
    reset_n = 1'b0;
    control = 32'd0;
    repeat (2) @(negedge clock);
    run_chk = 1'b1;
    lit("reset_out", 32'd0);

    apply(32'h0011_0FCB, 1'b1, 10); lit("add_r1", 32'd17);
    apply(32'h0832_0F4B, 1'b1, 10); lit("and_r1", 32'd16);
    apply(32'h1053_0ECB, 1'b1, 10); lit("xor_r1", 32'd17);
    apply(32'h1895_0DCB, 1'b1, 10); lit("sll_r1", 32'd176160768);

    apply(32'd0, 1'b0, 1);
    apply(mk(1, 0, 1, 3, 0), 1'b1, 10); lit("sub_neg", 32'hFFFF_FFFF);
    apply(mk(9, 3, 2, 4, 0), 1'b1, 10); lit("slt", 32'd1);
    apply(mk(10, 3, 2, 4, 0), 1'b1, 10); lit("sltu", 32'd0);
    apply(mk(8, 0, 3, 5, 4), 1'b1, 10); lit("sra", 32'hFFFF_FFFF);
    apply(mk(7, 0, 3, 6, 4), 1'b1, 10); lit("srl", 32'h0FFF_FFFF);

    apply(32'd0, 1'b0, 1);
    apply(mk(0, 1, 2, 0, 0), 1'b1, 10); lit("wr_r0_out", 32'd3);
    apply(mk(3, 0, 0, 7, 0), 1'b1, 10); lit("rd_r0", 32'd0);
    apply(mk(0, 1, 2, 8, 0), 1'b1, 10); lit("add_r8", 32'd3);
    apply(mk(0, 1, 1, 8, 0, 6'h20), 1'b1, 10); lit("nop_funct", 32'd3);
    apply(mk(12, 1, 1, 8, 0), 1'b1, 10); lit("nop_op12", 32'd3);
    apply(mk(3, 8, 0, 9, 0), 1'b1, 10); lit("r8_kept", 32'd3);
    apply(mk(0, 5, 5, 5, 0), 1'b1, 3);  lit("r5_doubled", 32'd40);
    apply(mk(0, 5, 5, 5, 0), 1'b0, 1);  lit("mid_reset", 32'd0);
    apply(mk(3, 5, 0, 10, 0), 1'b1, 10); lit("r5_after_rst", 32'd5);

    for (int n = 0; n < 600; n++) begin
      w = $urandom;
      w[31:26] = 6'($urandom_range(15));
      if ($urandom_range(7) != 0) w[5:0] = 6'b001011;
      apply(w, ($urandom_range(39) != 0), 1);
    end

    run_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
